// File: rtl/multicycle_control.sv
// Multicycle sequencing controller for a shared instruction/data memory port.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB/BRANCH/JUMP and
// drives the per-cycle datapath enables. Memory stalls and illegal opcodes
// lead to a sticky TRAP state.
//
// Ports:
//   clock, reset (async, active low)
//   opcode        IR[31:26], sampled in DECODE
//   mem_ready     memory completes the current request
//   mem_req/mem_we/iord                  memory control
//   ir_write/pc_write/pc_write_cond/pcsrc PC and IR control
//   alusrc/aluop                          ALU control
//   regdst/memtoreg/reg_write/link        register file control
//   instr_retired  pulse on the last cycle of an instruction
//   illegal/bus_error  sticky trap causes
//   state          current state for debug
module multicycle_control #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pcsrc,
    output logic       alusrc,
    output logic [1:0] aluop,
    output logic       regdst,
    output logic       memtoreg,
    output logic       reg_write,
    output logic       link,
    output logic       instr_retired,
    output logic       illegal,
    output logic       bus_error,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEM    = 4'd4,
        S_WB     = 4'd5,
        S_BRANCH = 4'd6,
        S_JUMP   = 4'd7,
        S_TRAP   = 4'd8
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    // Counter only needs to reach TIMEOUT-1.
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] CNT_LAST = CW'(LAST);

    state_t        state_q, state_d;
    logic [5:0]    op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          illegal_q, illegal_d;
    logic          bus_error_q, bus_error_d;

    logic is_r, is_lw, is_sw, is_imm_add, is_imm_log, is_jal;
    logic timed_out;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            cnt_q       <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            illegal_q   <= illegal_d;
            bus_error_q <= bus_error_d;
        end
    end

    // Later states decode only the opcode latched in DECODE.
    assign is_r       = (op_q == OP_R);
    assign is_lw      = (op_q == OP_LW);
    assign is_sw      = (op_q == OP_SW);
    assign is_imm_add = (op_q == OP_ADDI);
    assign is_imm_log = (op_q == OP_ORI) || (op_q == OP_LUI);
    assign is_jal     = (op_q == OP_JAL);

    // A ready in the final allowed cycle still completes normally.
    assign timed_out = (TIMEOUT > 0) && (cnt_q == CNT_LAST) && !mem_ready;

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        illegal_d     = illegal_q;
        bus_error_d   = bus_error_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pcsrc         = 2'b00;
        alusrc        = 1'b0;
        aluop         = 2'b00;
        regdst        = 1'b0;
        memtoreg      = 1'b0;
        reg_write     = 1'b0;
        link          = 1'b0;
        instr_retired = 1'b0;

        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timed_out) begin
                    bus_error_d = 1'b1;
                    state_d     = S_TRAP;
                end
            end
            S_DECODE: begin
                op_d = opcode;
                unique case (opcode)
                    OP_R, OP_LW, OP_SW, OP_ADDI, OP_ORI, OP_LUI:
                        state_d = S_EXEC;
                    OP_BEQ:
                        state_d = S_BRANCH;
                    OP_J, OP_JAL:
                        state_d = S_JUMP;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_TRAP;
                    end
                endcase
            end
            S_EXEC: begin
                unique case (1'b1)
                    is_r: begin
                        alusrc = 1'b0;
                        aluop  = 2'b10;
                    end
                    is_imm_log: begin
                        alusrc = 1'b1;
                        aluop  = 2'b11;
                    end
                    default: begin
                        alusrc = 1'b1;
                        aluop  = 2'b00;
                    end
                endcase
                state_d = (is_lw || is_sw) ? S_MEM : S_WB;
            end
            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = is_sw;
                if (mem_ready) begin
                    if (is_sw) begin
                        instr_retired = 1'b1;
                        state_d       = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timed_out) begin
                    bus_error_d = 1'b1;
                    state_d     = S_TRAP;
                end
            end
            S_WB: begin
                reg_write     = 1'b1;
                memtoreg      = is_lw;
                regdst        = is_r;
                instr_retired = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                alusrc        = 1'b0;
                aluop         = 2'b01;
                pc_write_cond = 1'b1;
                pcsrc         = 2'b01;
                instr_retired = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write      = 1'b1;
                pcsrc         = 2'b10;
                reg_write     = is_jal;
                link          = is_jal;
                instr_retired = 1'b1;
                state_d       = S_FETCH;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase

        // Clear on any state change so each FETCH/MEM starts from zero.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign illegal   = illegal_q;
    assign bus_error = bus_error_q;
    assign state     = state_q;

    // is_imm_add selects the same ALU setup as lw/sw in EXEC.
    logic unused_ok;
    assign unused_ok = is_imm_add;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control against a per-instruction
// transaction model of the expected state trace and outputs.
module tb_multicycle_control;

    localparam int TO = 16;

    localparam int S_I = 0;
    localparam int S_F = 1;
    localparam int S_D = 2;
    localparam int S_E = 3;
    localparam int S_M = 4;
    localparam int S_W = 5;
    localparam int S_B = 6;
    localparam int S_J = 7;
    localparam int S_T = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
    logic [1:0] pcsrc, aluop;
    logic       alusrc, regdst, memtoreg, reg_write, link;
    logic       instr_retired, illegal, bus_error;
    logic [3:0] state;

    int errs = 0;
    int checks = 0;
    bit m_ill = 1'b0;
    bit m_be = 1'b0;
    bit m_trap = 1'b0;

    multicycle_control #(.TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .opcode(opcode),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .pcsrc(pcsrc), .alusrc(alusrc),
        .aluop(aluop), .regdst(regdst), .memtoreg(memtoreg),
        .reg_write(reg_write), .link(link),
        .instr_retired(instr_retired), .illegal(illegal),
        .bus_error(bus_error), .state(state)
    );

    always #5 clock = ~clock;

    wire [17:0] dut_out = {mem_req, mem_we, iord, ir_write, pc_write,
                           pc_write_cond, pcsrc, alusrc, aluop, regdst,
                           memtoreg, reg_write, link, instr_retired,
                           illegal, bus_error};

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected outputs for one cycle, from the instruction class and phase.
    function automatic logic [17:0] exp_out(int st, logic [5:0] op, logic rdy);
        logic req, we, ad, irw, pcw, pcc, als, rdst, m2r, rw, lnk, ret;
        logic [1:0] psrc, aop;
        bit r, lw, sw, logi, jal;
        r = (op == 6'h00);
        lw = (op == 6'h23);
        sw = (op == 6'h2B);
        logi = (op == 6'h0D) || (op == 6'h0F);
        jal = (op == 6'h03);
        {req, we, ad, irw, pcw, pcc, als, rdst, m2r, rw, lnk, ret} = '0;
        psrc = 2'b00;
        aop = 2'b00;
        case (st)
            S_F: begin
                req = 1; irw = rdy; pcw = rdy;
            end
            S_E: begin
                als = !r;
                aop = r ? 2'b10 : (logi ? 2'b11 : 2'b00);
            end
            S_M: begin
                req = 1; ad = 1; we = sw; ret = sw && rdy;
            end
            S_W: begin
                rw = 1; m2r = lw; rdst = r; ret = 1;
            end
            S_B: begin
                aop = 2'b01; pcc = 1; psrc = 2'b01; ret = 1;
            end
            S_J: begin
                pcw = 1; psrc = 2'b10; rw = jal; lnk = jal; ret = 1;
            end
            default: ;
        endcase
        return {req, we, ad, irw, pcw, pcc, psrc, als, aop, rdst,
                m2r, rw, lnk, ret, m_ill, m_be};
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic step(int st, logic rdy);
        mem_ready = rdy;
        @(negedge clock);
        check($sformatf("state op%0h", opcode), 32'(state), 32'(st));
        check($sformatf("outs st%0d op%0h", st, opcode),
              32'(dut_out), 32'(exp_out(st, opcode, rdy)));
        @(posedge clock);
        #1;
    endtask

    // One memory phase: waits cycles of not-ready then ready, or a timeout.
    task automatic mem_phase(int st, int waits);
        for (int k = 0; k < TO; k++) begin
            if (k == waits) begin
                step(st, 1'b1);
                return;
            end
            step(st, 1'b0);
            if (k == TO - 1) begin
                m_be = 1'b1;
                m_trap = 1'b1;
                step(S_T, rnd());
                return;
            end
        end
    endtask

    task automatic run_instr(logic [5:0] op, int wf, int wm);
        opcode = op;
        mem_phase(S_F, wf);
        if (m_trap) return;
        step(S_D, rnd());
        case (op)
            6'h00, 6'h08, 6'h0D, 6'h0F: begin
                step(S_E, rnd());
                step(S_W, rnd());
            end
            6'h23, 6'h2B: begin
                step(S_E, rnd());
                mem_phase(S_M, wm);
                if (m_trap) return;
                if (op == 6'h23) step(S_W, rnd());
            end
            6'h04: step(S_B, rnd());
            6'h02, 6'h03: step(S_J, rnd());
            default: begin
                m_ill = 1'b1;
                m_trap = 1'b1;
                step(S_T, rnd());
            end
        endcase
    endtask

    task automatic do_reset();
        reset = 1'b0;
        mem_ready = rnd();
        m_ill = 1'b0;
        m_be = 1'b0;
        m_trap = 1'b0;
        #3;
        check("rst state", 32'(state), 32'(S_I));
        check("rst outs", 32'(dut_out), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    logic [5:0] legal_ops [9] = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h0D,
                                  6'h0F, 6'h04, 6'h02, 6'h03};

    initial begin
        do_reset();
        run_instr(6'h00, 0, 0);
        run_instr(6'h00, 0, 0);
        run_instr(6'h23, 0, 3);
        run_instr(6'h2B, 0, 0);
        run_instr(6'h04, 0, 0);
        run_instr(6'h03, 0, 0);

        repeat (60) begin
            run_instr(legal_ops[$urandom_range(0, 8)],
                      $urandom_range(0, 5), $urandom_range(0, 5));
        end

        run_instr(6'h3F, 1, 0);
        repeat (20) step(S_T, rnd());
        do_reset();
        run_instr(6'h0D, 0, 0);

        run_instr(6'h00, TO, 0);
        repeat (3) step(S_T, rnd());
        do_reset();
        run_instr(6'h00, TO - 1, 0);
        run_instr(6'h23, 2, TO - 1);
        run_instr(6'h2B, 0, TO);
        repeat (2) step(S_T, rnd());
        do_reset();

        opcode = 6'h2B;
        step(S_F, 1'b1);
        step(S_D, 1'b0);
        step(S_E, 1'b0);
        step(S_M, 1'b0);
        mem_ready = 1'b0;
        #2;
        check("pre-rst we", 32'(mem_we), 32'h1);
        reset = 1'b0;
        #1;
        check("rst state", 32'(state), 32'(S_I));
        check("rst req", 32'(mem_req), 32'h0);
        check("rst we", 32'(mem_we), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        run_instr(6'h00, 0, 0);
        run_instr(6'h02, 1, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
